keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, 2-flop row sync, debounce, one-hot key report.
// Optional macro KEY_REPEAT_EN adds auto-repeat reports while a key stays held.
module keypad_scanner #(
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CNT    = 8,
  parameter int REPEAT_CNT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [2:0]  col,
  output logic [11:0] scan_data,
  output logic        valid
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEB_CNT);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_REPORT   = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  if (SCAN_DIV < 4 || DEB_CNT < 2 || REPEAT_CNT < 2) begin : g_param_check
    $error("keypad_scanner: SCAN_DIV>=4, DEB_CNT>=2, REPEAT_CNT>=2 required");
  end

  state_t             state_r, state_s;
  logic [3:0]         row_meta_r, row_sync_r;
  logic [2:0]         col_r, col_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [DEB_W-1:0]   deb_r, deb_s;
  logic [DEB_W-1:0]   rel_r, rel_s;
  logic [1:0]         cand_row_r, cand_row_s;
  logic [1:0]         cand_col_r, cand_col_s;
  logic [11:0]        scan_data_r, scan_data_s;
  logic               valid_r, valid_s;
  logic               cand_bit_s;
`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT);
  logic [REP_W-1:0]   rep_r, rep_s;
`endif

  function automatic logic [1:0] lowest_row(input logic [3:0] r);
    if (r[0])      lowest_row = 2'd0;
    else if (r[1]) lowest_row = 2'd1;
    else if (r[2]) lowest_row = 2'd2;
    else           lowest_row = 2'd3;
  endfunction

  function automatic logic [1:0] col_index(input logic [2:0] c);
    case (c)
      3'b001:  col_index = 2'd0;
      3'b010:  col_index = 2'd1;
      3'b100:  col_index = 2'd2;
      default: col_index = 2'd0;
    endcase
  endfunction

  // A corrupted (non one-hot) column recovers to the first column.
  function automatic logic [2:0] next_col(input logic [2:0] c);
    case (c)
      3'b001:  next_col = 3'b010;
      3'b010:  next_col = 3'b100;
      default: next_col = 3'b001;
    endcase
  endfunction

  function automatic logic [11:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] idx;
    idx      = {2'b00, r} * 4'd3 + {2'b00, c};
    key_code = 12'd1 << idx;
  endfunction

  assign cand_bit_s = row_sync_r[cand_row_r];

  // Row synchronizer for the asynchronous keypad inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_r <= 4'h0;
      row_sync_r <= 4'h0;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // Next-state and next-output logic for the scan/debounce/report/release FSM.
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    div_s       = div_r;
    deb_s       = deb_r;
    rel_s       = rel_r;
    cand_row_s  = cand_row_r;
    cand_col_s  = cand_col_r;
    scan_data_s = scan_data_r;
    valid_s     = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_s       = rep_r;
`endif
    case (state_r)
      ST_SCAN: begin
        if (div_r == DIV_W'(SCAN_DIV - 1)) begin
          div_s = {DIV_W{1'b0}};
          if (row_sync_r != 4'h0) begin
            cand_row_s = lowest_row(row_sync_r);
            cand_col_s = col_index(col_r);
            deb_s      = {DEB_W{1'b0}};
            state_s    = ST_DEBOUNCE;
          end else begin
            col_s = next_col(col_r);
          end
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (cand_bit_s) begin
          if (deb_r == DEB_W'(DEB_CNT - 1)) begin
            state_s     = ST_REPORT;
            scan_data_s = key_code(cand_row_r, cand_col_r);
            valid_s     = 1'b1;
          end else begin
            deb_s = deb_r + DEB_W'(1);
          end
        end else begin
          state_s = ST_SCAN;
          col_s   = next_col(col_r);
          div_s   = {DIV_W{1'b0}};
        end
      end
      ST_REPORT: begin
        state_s = ST_RELEASE;
        rel_s   = {DEB_W{1'b0}};
`ifdef KEY_REPEAT_EN
        rep_s   = REP_W'(1);
`endif
      end
      ST_RELEASE: begin
        if (row_sync_r == 4'h0) begin
          if (rel_r == DEB_W'(DEB_CNT - 1)) begin
            state_s = ST_SCAN;
            col_s   = next_col(col_r);
            div_s   = {DIV_W{1'b0}};
          end else begin
            rel_s = rel_r + DEB_W'(1);
          end
        end else begin
          rel_s = {DEB_W{1'b0}};
        end
`ifdef KEY_REPEAT_EN
        // rep_r counts clocks since the last pulse, so repeats land REPEAT_CNT apart.
        if (cand_bit_s) begin
          if (rep_r == REP_W'(REPEAT_CNT - 1)) begin
            valid_s = 1'b1;
            rep_s   = {REP_W{1'b0}};
          end else begin
            rep_s = rep_r + REP_W'(1);
          end
        end else begin
          rep_s = {REP_W{1'b0}};
        end
`endif
      end
      default: begin
        state_s = ST_SCAN;
        col_s   = 3'b001;
        div_s   = {DIV_W{1'b0}};
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_SCAN;
      col_r       <= 3'b001;
      div_r       <= {DIV_W{1'b0}};
      deb_r       <= {DEB_W{1'b0}};
      rel_r       <= {DEB_W{1'b0}};
      cand_row_r  <= 2'd0;
      cand_col_r  <= 2'd0;
      scan_data_r <= 12'h000;
      valid_r     <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_r       <= {REP_W{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      col_r       <= col_s;
      div_r       <= div_s;
      deb_r       <= deb_s;
      rel_r       <= rel_s;
      cand_row_r  <= cand_row_s;
      cand_col_r  <= cand_col_s;
      scan_data_r <= scan_data_s;
      valid_r     <= valid_s;
`ifdef KEY_REPEAT_EN
      rep_r       <= rep_s;
`endif
    end
  end

  assign col       = col_r;
  assign scan_data = scan_data_r;
  assign valid     = valid_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from the column drive,
// expected key codes are queued at press time and a monitor checks every valid pulse.
module tb_keypad_scanner;
  localparam int SCAN_DIV   = 4;
  localparam int DEB_CNT    = 3;
  localparam int REPEAT_CNT = 20;
  localparam int MAX_LAT    = 3 * SCAN_DIV + DEB_CNT + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [11:0] scan_data;
  logic        valid;

  logic [11:0] keys      = 12'h000;
  logic        use_force = 1'b0;
  logic [3:0]  row_force = 4'h0;

  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;
  logic [11:0] last_data = 12'h000;
  logic        prev_valid = 1'b0;
  int n_checks = 0, n_fail = 0, n_repeat = 0;
  int cyc = 0, since = 0, press_cyc = 0, last_valid_cyc = 0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT), .REPEAT_CNT(REPEAT_CNT)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .scan_data(scan_data), .valid(valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad model: a pressed key connects its column drive to its row line.
  always_comb begin
    row = 4'h0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && col[c]) row[r] = 1'b1;
    if (use_force) row = row_force;
  end

  // Monitor: every valid pulse is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_checks++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL valid_back_to_back: valid high on two consecutive cycles, data %03h", scan_data);
      end else if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        if (scan_data !== mon_exp) begin
          n_fail++;
          $display("FAIL scan_data: got %03h expected %03h", scan_data, mon_exp);
        end
`ifdef KEY_REPEAT_EN
      end else if (scan_data === last_data && since == REPEAT_CNT - 1) begin
        n_repeat++;
`endif
      end else begin
        n_fail++;
        $display("FAIL unexpected_valid: got pulse with %03h expected no pulse (gap %0d)", scan_data, since + 1);
      end
      last_data      = scan_data;
      last_valid_cyc = cyc;
      since          = 0;
    end else begin
      since++;
    end
    prev_valid = valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input logic [2:0] c);
    for (int i = 0; i < 40 && col !== c; i++) @(negedge clk);
    check("wait_col", {29'd0, col}, {29'd0, c});
  endtask

  task automatic press(input logic [11:0] k, input logic [11:0] code);
    keys      = k;
    press_cyc = cyc;
    exp_q.push_back(code);
  endtask

  task automatic hold_release(input string name, input int hold);
    wait_clks(hold);
    keys = 12'h000;
    wait_clks(30);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    wait_clks(3);
    check("rst_col", {29'd0, col}, 32'h1);
    check("rst_scan_data", {20'd0, scan_data}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'h0);

    // Column rotation: one step every SCAN_DIV clocks after reset release.
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("col_rotate", {29'd0, col}, 32'd1 << ((k / SCAN_DIV) % 3));
      @(negedge clk);
    end

    // Key '5' held for 40 clocks: one report, bounded latency, data held afterwards.
    press(12'h010, 12'h010);
    hold_release("key5", 40);
    check("key5_latency_ok", {31'd0, (last_valid_cyc - press_cyc) <= MAX_LAT}, 32'd1);
    check("key5_hold_data", {20'd0, scan_data}, 32'h010);

    // Two-clock glitch on row3 in column 2: rejected, scanning continues.
    wait_col(3'b100);
    use_force = 1'b1;
    row_force = 4'b1000;
    wait_clks(2);
    row_force = 4'h0;
    wait_clks(20);
    use_force = 1'b0;
    check("glitch_no_report", exp_q.size(), 32'd0);
    wait_col(3'b001);
    wait_col(3'b010);

    // '#' held for 100 clocks.
    press(12'h800, 12'h800);
    hold_release("hash", 100);
`ifdef KEY_REPEAT_EN
    check("hash_repeats_ge3", {31'd0, n_repeat >= 3}, 32'd1);
`endif

    // '4' and '7' together: lower row wins, no second report.
    press(12'h048, 12'h008);
    hold_release("key4_7", 40);
    check("key4_hold_data", {20'd0, scan_data}, 32'h008);

    // Reset two clocks into debounce aborts the press.
    keys = 12'h001;
    for (int i = 0; i < 60 && dut.state_r !== 2'd1; i++) @(negedge clk);
    check("reach_debounce", {30'd0, dut.state_r}, 32'd1);
    wait_clks(2);
    rst = 1'b0;
    #1;
    check("abort_col", {29'd0, col}, 32'h1);
    check("abort_scan_data", {20'd0, scan_data}, 32'h0);
    check("abort_valid", {31'd0, valid}, 32'h0);
    keys = 12'h000;
    wait_clks(3);
    rst = 1'b1;
    wait_clks(2);
    press(12'h001, 12'h001);
    hold_release("key1_after_rst", 40);
    check("key1_hold_data", {20'd0, scan_data}, 32'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
